pwm_cmp: RTL and testbench
==========================

Name: pwm_cmp

Overview:
- Downstream consumer of the free-running up-counter: compares the counter value against a shadowed duty register and drives a complementary PWM pair with programmable dead time.
- The counter and this block share one clock.
- Duty updates are glitch-free: written values take effect only at the period boundary, which is the cycle with cnt == top.
- Used for motor/LED drive and as a duty-controlled clock source.

Parameters:
- width, 8, width of the counter value, top and duty.
- dtw, 4, width of the dead-time count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- cnt  in  width  counter value from the upstream counter, counting 0..top.
- top  in  width  counter top value; the period is top+1 cycles.
- en  in  1  output enable.
- duty  in  width  new duty value (number of high cycles per period).
- duty_wr  in  1  one-cycle strobe that captures duty into the shadow register.
- dead  in  dtw  dead-time length in clk cycles; 0 means no gap.
- pwm_h  out  1  high-side output, registered.
- pwm_l  out  1  low-side output, registered.
- pend  out  1  shadow holds a value not yet applied.
- upd  out  1  one-cycle pulse marking the boundary at which the shadow was applied.

Behaviour:
- Reset (async, rstn=0):
  - duty_act=0, shadow=0, pend=0, upd=0, pwm_h=0, pwm_l=0.
  - State IDLE, dead counter cleared.
  - A reset mid-period takes effect immediately.
- Shadow register:
  - duty_wr=1 loads shadow<=duty and sets pend=1.
  - Back-to-back writes: the last write wins.
- Boundary (cnt==top at the clock edge):
  - If pend, or duty_wr is asserted in the same cycle, duty_act<=shadow value (the incoming duty when written this cycle), pend<=0, upd<=1 for one cycle.
  - Otherwise duty_act is unchanged and upd=0.
- Raw compare (combinational): raw = (cnt < duty_act), unsigned, full width.
  - duty_act=0 gives constant low.
  - duty_act>top gives constant high.
- Output state machine, states IDLE, HI, LO, DT. DT holds the target level tgt and a down-counter dc.
  - IDLE: outputs 0/0. When en=1: if dead==0, go to HI (raw=1) or LO (raw=0); else go to DT with tgt=raw, dc=dead.
  - HI: pwm_h=1, pwm_l=0. If raw=0: go to LO when dead==0, else to DT with tgt=0, dc=dead.
  - LO: pwm_h=0, pwm_l=1. Mirror of HI.
  - DT: both outputs 0. dc decrements each cycle. At dc==1, go to the state for tgt.
  - DT abort: if raw differs from tgt while in DT, restart with tgt=raw, dc=dead. Pulses shorter than dead are therefore swallowed, and both outputs are never high together.
  - en=0 in any state: next state IDLE, outputs 0 on the next cycle.
- Latency:
  - With dead=0, an output follows raw one cycle later.
  - With dead=N, the newly active side asserts N+1 cycles after raw changes, and both outputs are low for exactly N cycles.
- Invariant: pwm_h & pwm_l == 0 in every cycle, including reset release and en toggling.
- top changing mid-period: no special handling; the boundary is taken from the live cnt==top compare.

Test Plan:
- Basic compare, dead=0: top=4, duty=2 written and applied at the first boundary, en=1. Required: pwm_h high for 2 of every 5 cycles, pwm_l high for 3, both lagging cnt by 1 cycle.
- Shadow timing: with duty_act=2, write duty=3 at cnt=1. Required: pend=1 until the cnt==4 cycle, then upd pulses once, and the next period has 3 high cycles; the current period is unaffected.
- Write in the boundary cycle and edge duties:
  - Writing duty=4 exactly in the cnt==top cycle takes effect in the following period, and pend stays 0.
  - duty=0 gives constant pwm_l=1.
  - duty=9 with top=4 gives constant pwm_h=1.
- Dead time: top=9, duty=5, dead=2. Required: each edge shows 2 cycles with both outputs low, pwm_h high for 3 cycles, pwm_l high for 3 cycles, and never both high.
- Short-pulse swallow: top=9, duty=1, dead=3. Required: pwm_h never asserts, and pwm_l stays low for 3 cycles after reset/enable, then high.
- Reset and disable mid-operation:
  - Drop en with pwm_h=1: both outputs are 0 on the next cycle, and re-enabling with dead=2 waits 2 cycles.
  - Assert rstn=0 asynchronously mid-period: outputs and pend clear immediately without waiting for a clock, and duty_act=0.

Source files
------------

// File: rtl/pwm_cmp.sv
// pwm_cmp: compares a free-running counter against a shadowed duty value and
// drives a complementary PWM pair with programmable dead time.
//
// Ports:
//   clk      system clock, rising edge
//   rstn     asynchronous active-low reset
//   cnt      counter value from the upstream counter (0..top)
//   top      counter top value; the period boundary is cnt == top
//   en       output enable
//   duty     new duty value (high cycles per period)
//   duty_wr  one-cycle strobe capturing duty into the shadow register
//   dead     dead-time length in clk cycles (0 = no gap)
//   pwm_h    high-side output, registered
//   pwm_l    low-side output, registered
//   pend     shadow holds a value not yet applied
//   upd      one-cycle pulse after the boundary at which the shadow was applied
module pwm_cmp #(
  parameter int unsigned width = 8,
  parameter int unsigned dtw   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [width-1:0] cnt,
  input  logic [width-1:0] top,
  input  logic             en,
  input  logic [width-1:0] duty,
  input  logic             duty_wr,
  input  logic [dtw-1:0]   dead,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             pend,
  output logic             upd
);

  typedef enum logic [1:0] {StIdle, StHi, StLo, StDt} state_e;

  state_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [dtw-1:0]   dc_q, dc_d;
  logic [width-1:0] shadow_q, shadow_d;
  logic [width-1:0] duty_act_q, duty_act_d;
  logic             pend_q, pend_d;
  logic             upd_q, upd_d;
  logic             pwm_h_q, pwm_l_q;

  logic boundary;
  logic raw;
  logic start;
  logic start_lvl;

  assign boundary = (cnt == top);
  assign raw      = (cnt < duty_act_q);

  // Shadow capture and boundary transfer. A write in the boundary cycle goes
  // straight to duty_act and never raises pend.
  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    duty_act_d = duty_act_q;
    upd_d      = 1'b0;
    if (duty_wr) begin
      shadow_d = duty;
      pend_d   = 1'b1;
    end
    if (boundary && (pend_q || duty_wr)) begin
      duty_act_d = duty_wr ? duty : shadow_q;
      pend_d     = 1'b0;
      upd_d      = 1'b1;
    end
  end

  // Output FSM. 'start' requests a move towards start_lvl, either directly
  // (no dead time) or through a fresh dead-time interval.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    dc_d      = dc_q;
    start     = 1'b0;
    start_lvl = 1'b0;
    if (!en) begin
      state_d = StIdle;
      dc_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          start     = 1'b1;
          start_lvl = raw;
        end
        StHi: begin
          if (!raw) begin
            start     = 1'b1;
            start_lvl = 1'b0;
          end
        end
        StLo: begin
          if (raw) begin
            start     = 1'b1;
            start_lvl = 1'b1;
          end
        end
        StDt: begin
          if (raw != tgt_q) begin
            // Level flipped during the gap: restart so short pulses vanish.
            start     = 1'b1;
            start_lvl = raw;
          end else if ((dc_q == '0) || (dc_q == dtw'(1))) begin
            state_d = tgt_q ? StHi : StLo;
            dc_d    = '0;
          end else begin
            dc_d = dc_q - dtw'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      if (start) begin
        if (dead == '0) begin
          state_d = start_lvl ? StHi : StLo;
          dc_d    = '0;
        end else begin
          state_d = StDt;
          tgt_d   = start_lvl;
          dc_d    = dead;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      tgt_q      <= 1'b0;
      dc_q       <= '0;
      shadow_q   <= '0;
      duty_act_q <= '0;
      pend_q     <= 1'b0;
      upd_q      <= 1'b0;
      pwm_h_q    <= 1'b0;
      pwm_l_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      dc_q       <= dc_d;
      shadow_q   <= shadow_d;
      duty_act_q <= duty_act_d;
      pend_q     <= pend_d;
      upd_q      <= upd_d;
      pwm_h_q    <= (state_d == StHi);
      pwm_l_q    <= (state_d == StLo);
    end
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;
  assign pend  = pend_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_pwm_cmp.sv
// Scoreboard bench for pwm_cmp. A reference model predicts the outputs for
// every clock cycle; a monitor pops and compares them on the falling edge.
module tb_pwm_cmp;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rstn;
  logic [W-1:0] cnt;
  logic [W-1:0] top;
  logic         en;
  logic [W-1:0] duty;
  logic         duty_wr;
  logic [D-1:0] dead;
  logic         pwm_h;
  logic         pwm_l;
  logic         pend;
  logic         upd;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 0;

  // Expected {pwm_h, pwm_l, pend, upd} for the coming cycle.
  logic [3:0] sb_q[$];

  pwm_cmp #(.width(W), .dtw(D)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cnt     (cnt),
    .top     (top),
    .en      (en),
    .duty    (duty),
    .duty_wr (duty_wr),
    .dead    (dead),
    .pwm_h   (pwm_h),
    .pwm_l   (pwm_l),
    .pend    (pend),
    .upd     (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. A side is active in the next cycle exactly when en has
  // been high and the compare result has favoured that side for the last
  // dead+1 sampled cycles; the duty path follows the shadow/boundary rules.
  initial begin : model
    int         run_h;
    int         run_l;
    logic [W-1:0] m_sh;
    logic [W-1:0] m_act;
    bit         m_pend;
    bit         m_raw;
    bit         e_h;
    bit         e_l;
    bit         e_upd;
    run_h = 0; run_l = 0; m_sh = '0; m_act = '0; m_pend = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        run_h = 0; run_l = 0; m_sh = '0; m_act = '0; m_pend = 0;
        sb_q.delete();
        sb_q.push_back(4'b0000);
      end else begin
        m_raw = (int'(cnt) < int'(m_act));
        if (en && m_raw) run_h = (run_h < 1000) ? run_h + 1 : run_h;
        else run_h = 0;
        if (en && !m_raw) run_l = (run_l < 1000) ? run_l + 1 : run_l;
        else run_l = 0;
        e_h = (run_h > int'(dead));
        e_l = (run_l > int'(dead));
        e_upd = 0;
        if (duty_wr) begin
          m_sh = duty;
          m_pend = 1;
        end
        if ((cnt == top) && m_pend) begin
          m_act = m_sh;
          m_pend = 0;
          e_upd = 1;
        end
        sb_q.push_back({e_h, e_l, m_pend, e_upd});
      end
      started = 1;
    end
  end

  initial begin : monitor
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        if (started) begin
          n_chk++;
          $display("FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
        end
      end else begin
        exp = sb_q.pop_front();
        check("sb_pwm_h", pwm_h, exp[3]);
        check("sb_pwm_l", pwm_l, exp[2]);
        check("sb_pend", pend, exp[1]);
        check("sb_upd", upd, exp[0]);
        check("sb_never_both", pwm_h & pwm_l, 0);
      end
    end
  end

  // Upstream counter advance; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cnt = (cnt >= top) ? '0 : cnt + 1'b1;
    duty_wr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    int guard;
    guard = 0;
    while (cnt != v && guard < 300) begin
      tick();
      guard++;
    end
    if (cnt != v) begin
      n_chk++;
      $display("FAIL wait_cnt: got cnt %0d, expected %0d (t=%0t)", cnt, v, $time);
    end
  endtask

  task automatic write_duty(input logic [W-1:0] d);
    duty = d;
    duty_wr = 1'b1;
    tick();
  endtask

  task automatic count_out(input int n, output int nh, output int nl, output int nu);
    nh = 0; nl = 0; nu = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      nh += int'(pwm_h);
      nl += int'(pwm_l);
      nu += int'(upd);
    end
  endtask

  initial begin : stim
    int nh;
    int nl;
    int nu;
    rstn = 1'b0; en = 1'b0; cnt = '0; top = 8'd4; duty = '0; duty_wr = 1'b0; dead = '0;
    ticks(3);
    rstn = 1'b1;
    ticks(2);

    // Basic compare with no dead time.
    write_duty(8'd2);
    en = 1'b1;
    ticks(12);
    count_out(5, nh, nl, nu);
    check("basic_h_cycles", nh, 2);
    check("basic_l_cycles", nl, 3);

    // Shadow write mid-period.
    wait_cnt(8'd1);
    write_duty(8'd3);
    check("shadow_pend", pend, 1);
    count_out(6, nh, nl, nu);
    check("shadow_upd_once", nu, 1);
    ticks(4);
    count_out(5, nh, nl, nu);
    check("shadow_h_cycles", nh, 3);

    // Write in the boundary cycle.
    wait_cnt(8'd4);
    write_duty(8'd4);
    check("bnd_pend", pend, 0);
    check("bnd_upd", upd, 1);
    ticks(6);
    count_out(5, nh, nl, nu);
    check("bnd_h_cycles", nh, 4);
    check("bnd_l_cycles", nl, 1);

    // Edge duties.
    write_duty(8'd0);
    ticks(12);
    count_out(5, nh, nl, nu);
    check("duty0_l_cycles", nl, 5);
    write_duty(8'd9);
    ticks(12);
    count_out(5, nh, nl, nu);
    check("duty9_h_cycles", nh, 5);

    // Disable with pwm_h high, re-enable with dead time.
    en = 1'b0;
    dead = 4'd2;
    tick();
    check("dis_h", pwm_h, 0);
    check("dis_l", pwm_l, 0);
    en = 1'b1;
    tick();
    check("reen_gap1_h", pwm_h, 0);
    tick();
    check("reen_gap2_h", pwm_h, 0);
    tick();
    check("reen_h", pwm_h, 1);

    // Dead time on both edges.
    en = 1'b0;
    top = 8'd9;
    write_duty(8'd5);
    ticks(12);
    en = 1'b1;
    ticks(25);
    count_out(10, nh, nl, nu);
    check("dt_h_cycles", nh, 3);
    check("dt_l_cycles", nl, 3);

    // Short pulse swallowed by dead time.
    en = 1'b0;
    dead = 4'd3;
    write_duty(8'd1);
    ticks(12);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("swallow_l_gap", pwm_l, 0);
    end
    count_out(20, nh, nl, nu);
    check("swallow_h_never", nh, 0);

    // Asynchronous reset mid-period with a pending write.
    wait_cnt(8'd2);
    write_duty(8'd7);
    check("pre_rst_pend", pend, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_h", pwm_h, 0);
    check("rst_l", pwm_l, 0);
    check("rst_pend", pend, 0);
    check("rst_upd", upd, 0);
    ticks(3);
    rstn = 1'b1;
    ticks(20);

    // Randomized operation; dead only changes while disabled.
    en = 1'b0;
    dead = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        duty = 8'($urandom_range(15));
        duty_wr = 1'b1;
      end
      if ($urandom_range(199) == 0) top = 8'($urandom_range(12, 2));
      en = ($urandom_range(19) != 0);
      if (!en) dead = 4'($urandom_range(3));
      tick();
    end
    en = 1'b0;
    ticks(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
